// File: rtl/i2s_streamer_pkg.sv
// Shared types and constants for the I2S row streamer.
package i2s_streamer_pkg;

  localparam int unsigned HEADER_W = 16;
  localparam int unsigned WORD_W   = 16;
  localparam logic [1:0]  HDR_PAD  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StStall,
    StDone
  } state_e;

  // Words per frame: (nx + 1) * (ny + 1), range 1..256.
  function automatic logic [8:0] calc_words(input logic [3:0] nx, input logic [3:0] ny);
    logic [8:0] wx;
    logic [8:0] wy;
    wx = {5'd0, nx} + 9'd1;
    wy = {5'd0, ny} + 9'd1;
    return wx * wy;
  endfunction

endpackage

// File: rtl/i2s_shift_out.sv
// 16-bit parallel-load, MSB-first shift register driving the serial data line.
module i2s_shift_out
  import i2s_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic              msb
);

  logic [WORD_W-1:0] sr_q;

  // Load has priority over shift; the register holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_data;
    end else if (shift) begin
      sr_q <= {sr_q[WORD_W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WORD_W-1];

endmodule

// File: rtl/i2s_row_streamer.sv
// Streams one row frame (header + N pixel words) over a two-wire serial link.
// Each bit spans two clk cycles: i2s_clk low, then high.
// Build option: I2S_STREAMER_UNDERRUN_FILL_EN replaces the stall on a missing
// word with a zero fill word and a sticky underrun flag.
module i2s_row_streamer
  import i2s_streamer_pkg::*;
#(
  parameter int unsigned ROW_WRAP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  num_modules_x,
  input  logic [3:0]  num_modules_y,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        i2s_clk,
  output logic        i2s_data,
  output logic        busy,
  output logic [5:0]  row_num,
  output logic        row_done,
  output logic        underrun
);

  state_e      state_q, state_d;
  logic        clk_q, clk_d;
  logic        busy_q, row_done_q;
  logic [5:0]  row_num_q, row_num_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  // Word count latched at start; later changes to num_modules_x/y are ignored.
  logic [8:0]  n_words_q, n_words_d;
  logic        sr_load, sr_shift;
  logic [WORD_W-1:0] sr_data;
  logic        last_bit_high;
  logic        words_left;
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
  logic        underrun_q, underrun_d;
`endif

  // High phase of the final bit of the word currently being shifted out.
  assign last_bit_high = clk_q && (bit_cnt_q == 4'hF);
  assign words_left    = (word_cnt_q != n_words_q);

  // Ready only in the cycle that the next word would be loaded.
  assign word_ready = (state_q == StStall) ||
                      (((state_q == StHeader) || (state_q == StData)) &&
                       last_bit_high && words_left);

  // Next-state, bit timing and shift register control.
  always_comb begin
    state_d    = state_q;
    clk_d      = 1'b0;
    row_num_d  = row_num_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    n_words_d  = n_words_q;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_data    = '0;
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
    underrun_d = underrun_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StHeader;
          n_words_d  = calc_words(num_modules_x, num_modules_y);
          word_cnt_d = '0;
          bit_cnt_d  = '0;
          sr_load    = 1'b1;
          sr_data    = {num_modules_x, num_modules_y, HDR_PAD, row_num_q};
        end
      end
      StHeader, StData: begin
        if (!clk_q) begin
          clk_d = 1'b1;
        end else if (bit_cnt_q != 4'hF) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (!words_left) begin
          state_d   = StDone;
          row_num_d = (row_num_q == 6'(ROW_WRAP - 1)) ? 6'd0 : row_num_q + 6'd1;
        end else if (word_valid) begin
          state_d    = StData;
          sr_load    = 1'b1;
          sr_data    = word_data;
          word_cnt_d = word_cnt_q + 9'd1;
          bit_cnt_d  = '0;
        end else begin
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
          state_d    = StData;
          sr_load    = 1'b1;
          sr_data    = '0;
          word_cnt_d = word_cnt_q + 9'd1;
          bit_cnt_d  = '0;
          underrun_d = 1'b1;
`else
          // i2s_clk parks low and the data line keeps the last bit.
          state_d = StStall;
`endif
        end
      end
      StStall: begin
        if (word_valid) begin
          state_d    = StData;
          sr_load    = 1'b1;
          sr_data    = word_data;
          word_cnt_d = word_cnt_q + 9'd1;
          bit_cnt_d  = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      clk_q      <= 1'b0;
      busy_q     <= 1'b0;
      row_done_q <= 1'b0;
      row_num_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      n_words_q  <= '0;
    end else begin
      state_q    <= state_d;
      clk_q      <= clk_d;
      busy_q     <= (state_d != StIdle);
      row_done_q <= (state_d == StDone);
      row_num_q  <= row_num_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      n_words_q  <= n_words_d;
    end
  end

`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
  // Sticky underrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  i2s_shift_out u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (sr_data),
    .msb       (i2s_data)
  );

  assign i2s_clk  = clk_q;
  assign busy     = busy_q;
  assign row_done = row_done_q;
  assign row_num  = row_num_q;

endmodule

// File: tb/tb_i2s_row_streamer.sv
// Directed bench for i2s_row_streamer: frame format, timing, row wrap, stall,
// mid-frame reset and ignored start requests.
module tb_i2s_row_streamer;

  localparam int unsigned RowWrap = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_modules_x = '0;
  logic [3:0]  num_modules_y = '0;
  logic [15:0] word_data;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        i2s_clk;
  logic        i2s_data;
  logic        busy;
  logic [5:0]  row_num;
  logic        row_done;
  logic        underrun;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int c_start = 0;
  logic [5:0] exp_row = '0;

  logic        rx_bits[$];
  logic [15:0] sent[$];
  logic [7:0]  widx = '0;

  i2s_row_streamer #(
    .ROW_WRAP (RowWrap)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_modules_x (num_modules_x),
    .num_modules_y (num_modules_y),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .i2s_clk       (i2s_clk),
    .i2s_data      (i2s_data),
    .busy          (busy),
    .row_num       (row_num),
    .row_done      (row_done),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  // Distinct word per transfer so lost or repeated words show up.
  assign word_data = {widx ^ 8'hA5, widx + 8'h3C};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (word_valid && word_ready) begin
      sent.push_back(word_data);
      widx <= widx + 8'd1;
    end
  end

  // Serial receiver: sample data on the rising edge of i2s_clk.
  always @(posedge i2s_clk) rx_bits.push_back(i2s_data);

  function automatic logic [15:0] rx_word(input int base, input int idx);
    logic [15:0] w;
    w = '0;
    for (int b = 0; b < 16; b++) w = {w[14:0], rx_bits[base + idx * 16 + b]};
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_row = '0;
  endtask

  task automatic do_start(input logic [3:0] nx, input logic [3:0] ny);
    @(negedge clk);
    num_modules_x = nx;
    num_modules_y = ny;
    start = 1'b1;
    c_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int ncyc);
    while (row_done !== 1'b1 && (cyc - c_start) < limit) @(negedge clk);
    ncyc = cyc - c_start;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({i2s_clk, i2s_data, busy, row_done, underrun, word_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {i2s_clk, i2s_data, busy, row_done, underrun, word_ready});
    end
    n_checks++;
    if (row_num !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_row_num: got %0d, expected 0", row_num);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_row = '0;
  endtask

  task automatic test_basic();
    int rb, sb, ncyc;
    logic [15:0] got, expw;
    word_valid = 1'b1;
    rb = rx_bits.size();
    sb = sent.size();
    do_start(4'd3, 4'd3);
    n_checks++;
    if ({i2s_clk, i2s_data, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL first_bit_cycle1: got clk/data/busy %b, expected 001",
               {i2s_clk, i2s_data, busy});
    end
    @(negedge clk);
    n_checks++;
    if (i2s_clk !== 1'b1) begin
      n_fail++;
      $display("FAIL first_rise_cycle2: got %b, expected 1", i2s_clk);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({i2s_clk, i2s_data} !== 2'b01) begin
      n_fail++;
      $display("FAIL third_bit_cycle5: got clk/data %b, expected 01", {i2s_clk, i2s_data});
    end
    wait_done(700, ncyc);
    n_checks++;
    if (ncyc !== 545) begin
      n_fail++;
      $display("FAIL basic_row_done_cycle: got %0d, expected 545", ncyc);
    end
    n_checks++;
    if (rx_bits.size() - rb !== 272) begin
      n_fail++;
      $display("FAIL basic_bit_count: got %0d, expected 272", rx_bits.size() - rb);
    end
    n_checks++;
    if (sent.size() - sb !== 16) begin
      n_fail++;
      $display("FAIL basic_word_count: got %0d, expected 16", sent.size() - sb);
    end
    if (rx_bits.size() - rb >= 272 && sent.size() - sb >= 16) begin
      got = rx_word(rb, 0);
      n_checks++;
      if (got !== 16'h3300) begin
        n_fail++;
        $display("FAIL basic_header: got %h, expected 3300", got);
      end
      for (int k = 0; k < 16; k++) begin
        got = rx_word(rb, k + 1);
        expw = sent[sb + k];
        n_checks++;
        if (got !== expw) begin
          n_fail++;
          $display("FAIL basic_word%0d: got %h, expected %h", k, got, expw);
        end
      end
    end
    exp_row = 6'd1;
    n_checks++;
    if (row_num !== exp_row) begin
      n_fail++;
      $display("FAIL basic_row_num: got %0d, expected %0d", row_num, exp_row);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, row_done, i2s_clk} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_idle_after: got busy/done/clk %b, expected 000",
               {busy, row_done, i2s_clk});
    end
  endtask

  task automatic test_row_wrap();
    int rb, ncyc;
    logic [15:0] got, exph;
    do_reset();
    word_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rb = rx_bits.size();
      exph = {4'd2, 4'd1, 2'b00, 6'(i % RowWrap)};
      do_start(4'd2, 4'd1);
      wait_done(300, ncyc);
      n_checks++;
      if (ncyc !== 7 * 32 + 1) begin
        n_fail++;
        $display("FAIL wrap%0d_cycles: got %0d, expected %0d", i, ncyc, 7 * 32 + 1);
      end
      got = (rx_bits.size() - rb >= 16) ? rx_word(rb, 0) : 16'hxxxx;
      n_checks++;
      if (got !== exph) begin
        n_fail++;
        $display("FAIL wrap%0d_header: got %h, expected %h", i, got, exph);
      end
      @(negedge clk);
    end
    exp_row = 6'(9 % RowWrap);
  endtask

  task automatic test_stall();
    int rb, sb, ncyc, t;
    logic [15:0] w2, got, expw, exph;
    word_valid = 1'b1;
    rb = rx_bits.size();
    sb = sent.size();
    exph = {4'd1, 4'd1, 2'b00, exp_row};
    do_start(4'd1, 4'd1);
    t = 0;
    while (sent.size() - sb < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    word_valid = 1'b0;
    t = 0;
    while (word_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (cyc - c_start !== 96) begin
      n_fail++;
      $display("FAIL stall_ready_cycle: got %0d, expected 96", cyc - c_start);
    end
    w2 = (sent.size() - sb >= 2) ? sent[sb + 1] : 16'hxxxx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({i2s_clk, i2s_data, word_ready, busy} !== {1'b0, w2[0], 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got clk/data/ready/busy %b, expected %b", i,
                 {i2s_clk, i2s_data, word_ready, busy}, {1'b0, w2[0], 1'b1, 1'b1});
      end
    end
    word_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (i2s_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_resume_low: got %b, expected 0", i2s_clk);
    end
    wait_done(400, ncyc);
    n_checks++;
    if (ncyc !== 166) begin
      n_fail++;
      $display("FAIL stall_row_done_cycle: got %0d, expected 166", ncyc);
    end
    n_checks++;
    if (sent.size() - sb !== 4 || rx_bits.size() - rb !== 80) begin
      n_fail++;
      $display("FAIL stall_counts: got words %0d bits %0d, expected 4 and 80",
               sent.size() - sb, rx_bits.size() - rb);
    end else begin
      got = rx_word(rb, 0);
      n_checks++;
      if (got !== exph) begin
        n_fail++;
        $display("FAIL stall_header: got %h, expected %h", got, exph);
      end
      for (int k = 0; k < 4; k++) begin
        got = rx_word(rb, k + 1);
        expw = sent[sb + k];
        n_checks++;
        if (got !== expw) begin
          n_fail++;
          $display("FAIL stall_word%0d: got %h, expected %h", k, got, expw);
        end
      end
    end
    exp_row = (exp_row == 6'(RowWrap - 1)) ? 6'd0 : exp_row + 6'd1;
    @(negedge clk);
  endtask

`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
  task automatic test_fill();
    int rb, sb, ncyc, t;
    logic [15:0] got, expw;
    word_valid = 1'b1;
    rb = rx_bits.size();
    sb = sent.size();
    do_start(4'd3, 4'd3);
    t = 0;
    while (sent.size() - sb < 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    word_valid = 1'b0;
    t = 0;
    while (word_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_underrun_before: got %b, expected 0", underrun);
    end
    @(negedge clk);
    word_valid = 1'b1;
    n_checks++;
    if ({underrun, i2s_clk} !== 2'b10) begin
      n_fail++;
      $display("FAIL fill_underrun_set: got underrun/clk %b, expected 10", {underrun, i2s_clk});
    end
    wait_done(700, ncyc);
    n_checks++;
    if (ncyc !== 17 * 32 + 1) begin
      n_fail++;
      $display("FAIL fill_row_done_cycle: got %0d, expected %0d", ncyc, 17 * 32 + 1);
    end
    n_checks++;
    if (sent.size() - sb !== 15 || rx_bits.size() - rb !== 272) begin
      n_fail++;
      $display("FAIL fill_counts: got words %0d bits %0d, expected 15 and 272",
               sent.size() - sb, rx_bits.size() - rb);
    end else begin
      for (int k = 1; k <= 16; k++) begin
        got = rx_word(rb, k);
        expw = (k == 2) ? 16'h0000 : sent[sb + ((k < 2) ? k - 1 : k - 2)];
        n_checks++;
        if (got !== expw) begin
          n_fail++;
          $display("FAIL fill_word%0d: got %h, expected %h", k, got, expw);
        end
      end
    end
    exp_row = (exp_row == 6'(RowWrap - 1)) ? 6'd0 : exp_row + 6'd1;
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_underrun_sticky: got %b, expected 1", underrun);
    end
  endtask
`endif

  task automatic test_start_ignored();
    int rb, sb, ncyc;
    logic [15:0] got, exph;
    word_valid = 1'b1;
    rb = rx_bits.size();
    sb = sent.size();
    exph = {4'd1, 4'd2, 2'b00, exp_row};
    do_start(4'd1, 4'd2);
    repeat (40) @(negedge clk);
    num_modules_x = 4'hF;
    num_modules_y = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, ncyc);
    start = 1'b1;
    n_checks++;
    if (ncyc !== 7 * 32 + 1) begin
      n_fail++;
      $display("FAIL ignore_row_done_cycle: got %0d, expected %0d", ncyc, 7 * 32 + 1);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, i2s_clk} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_start_in_done: got busy/clk %b, expected 00", {busy, i2s_clk});
    end
    n_checks++;
    if (sent.size() - sb !== 6) begin
      n_fail++;
      $display("FAIL ignore_word_count: got %0d, expected 6", sent.size() - sb);
    end
    got = (rx_bits.size() - rb >= 16) ? rx_word(rb, 0) : 16'hxxxx;
    n_checks++;
    if (got !== exph) begin
      n_fail++;
      $display("FAIL ignore_header: got %h, expected %h", got, exph);
    end
    exp_row = (exp_row == 6'(RowWrap - 1)) ? 6'd0 : exp_row + 6'd1;
    n_checks++;
    if (row_num !== exp_row) begin
      n_fail++;
      $display("FAIL ignore_row_num: got %0d, expected %0d", row_num, exp_row);
    end
    num_modules_x = '0;
    num_modules_y = '0;
  endtask

  task automatic test_reset_mid();
    int rb, sb, ncyc, t;
    logic [15:0] got;
    word_valid = 1'b1;
    sb = sent.size();
    do_start(4'd3, 4'd3);
    t = 0;
    while (sent.size() - sb < 5 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({i2s_clk, i2s_data, busy, row_done, underrun, word_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, expected 000000",
               {i2s_clk, i2s_data, busy, row_done, underrun, word_ready});
    end
    n_checks++;
    if (row_num !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_row_num: got %0d, expected 0", row_num);
    end
    rb = rx_bits.size();
    repeat (4) @(negedge clk);
    n_checks++;
    if (rx_bits.size() - rb !== 0 || i2s_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_edges: got %0d edges clk %b, expected 0 edges clk 0",
               rx_bits.size() - rb, i2s_clk);
    end
    rst_n = 1'b1;
    exp_row = '0;
    rb = rx_bits.size();
    do_start(4'd0, 4'd0);
    wait_done(200, ncyc);
    n_checks++;
    if (ncyc !== 65) begin
      n_fail++;
      $display("FAIL midreset_new_frame_cycles: got %0d, expected 65", ncyc);
    end
    got = (rx_bits.size() - rb >= 16) ? rx_word(rb, 0) : 16'hxxxx;
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_header: got %h, expected 0000", got);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row_wrap();
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
    test_fill();
`else
    test_stall();
`endif
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_row_streamer.md
I2S_ROW_STREAMER -- requirements
Module: i2s_row_streamer

Interface
REQ-001 SHALL have parameter ROW_WRAP, default 8; row counter wraps to 0 when it reaches this value (1..64).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to send one row frame.
REQ-005 SHALL have port num_modules_x, input, 4, module count in x minus one.
REQ-006 SHALL have port num_modules_y, input, 4, module count in y minus one.
REQ-007 SHALL have port word_data, input, 16, next pixel word.
REQ-008 SHALL have port word_valid, input, 1, word_data is valid.
REQ-009 SHALL have port word_ready, output, 1, streamer accepts word_data in this cycle.
REQ-010 SHALL have port i2s_clk, output, 1, serial bit clock; low when idle.
REQ-011 SHALL have port i2s_data, output, 1, serial data; receivers sample on i2s_clk rising edge.
REQ-012 SHALL have port busy, output, 1, frame in progress.
REQ-013 SHALL have port row_num, output, 6, row number of the next frame to send.
REQ-014 SHALL have port row_done, output, 1, one-cycle pulse at frame end.
REQ-015 SHALL have port underrun, output, 1, sticky flag, fill-mode only (REQ-034).

Function
REQ-016 Frame SHALL be a 16-bit header {num_modules_x, num_modules_y, 2'b00, row_num}, then N=(num_modules_x+1)*(num_modules_y+1) words, all MSB first.
REQ-017 N SHALL be computed 9 bits wide (1..256); num_modules_x/y latched on start acceptance.
REQ-018 States SHALL be IDLE, HEADER, DATA, STALL, DONE.
REQ-019 IDLE: start=1 -> HEADER; the header is loaded into the shift register and busy=1 on the next edge.
REQ-020 Each bit SHALL occupy 2 clk cycles: i2s_clk low for 1 cycle, then high for 1 cycle; i2s_data changes only on the edge that drives i2s_clk low.
REQ-021 First header bit SHALL appear on i2s_data together with i2s_clk low, 1 cycle after the start cycle; the first rising edge of i2s_clk follows 1 cycle later.
REQ-022 After the 16th bit's high phase, HEADER SHALL go to DATA. DATA SHALL do the same after each word's 16th bit while words remain. The next word is loaded with no gap bit.
REQ-023 word_ready SHALL be 1 only in the cycle the shift register needs a new word (high phase of bit 0, or STALL); transfer = word_valid & word_ready.
REQ-024 Word needed and word_valid=0 -> STALL; i2s_clk held low; i2s_data holds the last bit; on valid, load and resume with a low phase.
REQ-025 After word N, SHALL enter DONE for 1 cycle: row_done=1, i2s_clk=0, row_num increments (ROW_WRAP-1 -> 0), then IDLE with busy=0.
REQ-026 start while busy SHALL be ignored; start asserted in DONE SHALL be ignored.
REQ-027 i2s_clk, i2s_data, busy, row_done SHALL be registered outputs.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, i2s_clk=0, i2s_data=0, busy=0, row_done=0, row_num=0, underrun=0, word_ready=0.
REQ-029 Reset mid-frame SHALL abort the frame with no further i2s_clk edges; row_num returns to 0.

Configuration
REQ-030 Macro I2S_STREAMER_UNDERRUN_FILL_EN SHALL select underrun behaviour.
REQ-031 Undefined: STALL behaviour per REQ-024; underrun tied 0.
REQ-032 Defined: no STALL state. If the word is needed and word_valid=0, send 16'h0000 and set underrun, which stays set until reset.
REQ-033 Defined: i2s_clk SHALL toggle continuously through the frame. Frame length is fixed at (N+1)*32 clk cycles.
REQ-034 Defined: underrun is 1 from the cycle after the fill word is loaded.

Structure
REQ-035 Package i2s_streamer_pkg SHALL hold the state enum, HEADER_W=16, WORD_W=16 and the header pad constant 2'b00.
REQ-036 Sub-module i2s_shift_out SHALL hold a 16-bit parallel-load, MSB-first shift register with load/shift enables.

Verification
REQ-037 nx=3, ny=3, row_num=0, word_valid held 1 -> header 16'h3300 MSB first, then 16 words; 272 bits; row_done after 544+1 cycles; row_num=1.
REQ-038 Eight consecutive frames with ROW_WRAP=8 -> header row fields 0..7; the ninth frame carries 0.
REQ-039 word_valid drops for 5 cycles before word 3 -> i2s_clk low for 5+ cycles; word 3 bits correct after resume; no lost or duplicated word.
REQ-040 With the fill macro, word_valid=0 for word 2 -> word 2 is 16'h0000; underrun=1; total frame 17*32 cycles for nx=ny=3.
REQ-041 rst_n pulsed low during word 5 -> outputs at reset values immediately; a new start sends header row 0.
REQ-042 start pulsed during busy, and nx/ny changed mid-frame -> no effect; word count stays from the latched values.
